// File: rtl/rf_riscv_mp_pkg.sv
// Shared types and defaults for the multi-port RISC-V integer register file.
// Holds the clear/ready state encoding and the address-width helper.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rf_riscv_mp_if.sv
// Bus bundle between the pipeline and the register file.
// Writes and scoreboard sets have no handshake: they take effect only on an edge where
// ready_o is 1; anything presented while ready_o is 0 is dropped, never queued.
interface rf_riscv_mp_if
  import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = rf_aw(NREGS);

    logic [NRD*AW-1:0]   read_addr_i;
    logic [NRD*XLEN-1:0] read_data_o;
    logic [NRD-1:0]      read_pending_o;
    logic                write_enable_i;
    logic [AW-1:0]       write_addr_i;
    logic [XLEN-1:0]     write_data_i;
    logic                pend_set_i;
    logic [AW-1:0]       pend_addr_i;
    logic                ready_o;

    modport master (
        output read_addr_i, write_enable_i, write_addr_i, write_data_i, pend_set_i, pend_addr_i,
        input  read_data_o, read_pending_o, ready_o
    );

    modport slave (
        input  read_addr_i, write_enable_i, write_addr_i, write_data_i, pend_set_i, pend_addr_i,
        output read_data_o, read_pending_o, ready_o
    );

endinterface

// File: rtl/rf_riscv_mp_scoreboard.sv
// Per-register pending bits for the hazard unit, with NRD combinational read taps.
// A set and a clear to the same register on one edge leave the bit set.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     clr_addr_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    rd_pend_o
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Set is applied after clear so a same-cycle issue keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_addr_i] = 1'b0;
        if (set_i) pend_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_tap
        assign rd_pend_o[k] = pend_q[rd_addr_i[k*AW +: AW]];
    end

endmodule

// File: rtl/rf_riscv_mp.sv
// Parametrised multi-read-port register file: x0 hardwired to zero, optional write bypass,
// pending scoreboard, and a sequential post-reset clear so the array needs no reset.
module rf_riscv_mp
  import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rf_riscv_mp_if.slave  bus,
    output rf_state_e     dbg_state_o
);

    localparam int AW = rf_aw(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            clr_we;
    logic            ready;
    logic            wr_ok;
    logic            set_ok;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [NRD-1:0]  sb_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                idx_d  = idx_q + AW'(1);
                if (idx_q == LAST_IDX) state_d = READY;
            end
            READY: state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign ready       = (state_q == READY);
    assign bus.ready_o = ready;
    assign dbg_state_o = state_q;
    assign wr_ok       = ready && bus.write_enable_i && (bus.write_addr_i != '0);
    assign set_ok      = ready && bus.pend_set_i && (bus.pend_addr_i != '0);

    // Array has no reset port; x0 is never written and is masked on every read instead.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clr_we)     rf_q[idx_q] <= '0;
            else if (wr_ok) rf_q[bus.write_addr_i] <= bus.write_data_i;
        end
    end

    rf_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (set_ok),
        .set_addr_i (bus.pend_addr_i),
        .clr_i      (wr_ok),
        .clr_addr_i (bus.write_addr_i),
        .rd_addr_i  (bus.read_addr_i),
        .rd_pend_o  (sb_pend)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] d;
        logic            p;

        assign ra  = bus.read_addr_i[k*AW +: AW];
        assign hit = (BYPASS != 0) && wr_ok && (bus.write_addr_i == ra);

        always_comb begin
            d = rf_q[ra];
            p = sb_pend[k];
            if (hit) begin
                d = bus.write_data_i;
                p = set_ok && (bus.pend_addr_i == ra);
            end
            if (ra == '0 || !ready) begin
                d = '0;
                p = 1'b0;
            end
        end

        assign bus.read_data_o[k*XLEN +: XLEN] = d;
        assign bus.read_pending_o[k]           = p;
    end

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Directed bench for rf_riscv_mp: two instances (bypass on / off) share one stimulus stream
// and are compared against hand-computed values.
module tb_rf_riscv_mp;
  import rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] raddr = '0;
  logic              we = 1'b0;
  logic [AW-1:0]     wa = '0;
  logic [XLEN-1:0]   wd = '0;
  logic              ps = 1'b0;
  logic [AW-1:0]     pa = '0;

  rf_riscv_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();
  rf_riscv_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_n ();

  assign bus_b.read_addr_i    = raddr;
  assign bus_b.write_enable_i = we;
  assign bus_b.write_addr_i   = wa;
  assign bus_b.write_data_i   = wd;
  assign bus_b.pend_set_i     = ps;
  assign bus_b.pend_addr_i    = pa;
  assign bus_n.read_addr_i    = raddr;
  assign bus_n.write_enable_i = we;
  assign bus_n.write_addr_i   = wa;
  assign bus_n.write_data_i   = wd;
  assign bus_n.pend_set_i     = ps;
  assign bus_n.pend_addr_i    = pa;

  rf_state_e st_b, st_n;

  rf_riscv_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .dbg_state_o(st_b)
  );
  rf_riscv_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .bus(bus_n.slave), .dbg_state_o(st_n)
  );

  logic [XLEN-1:0] rd_b [NRD];
  logic [XLEN-1:0] rd_n [NRD];
  logic [NRD-1:0]  pd_b, pd_n;
  for (genvar k = 0; k < NRD; k++) begin : g_tap
    assign rd_b[k] = bus_b.read_data_o[k*XLEN +: XLEN];
    assign rd_n[k] = bus_n.read_data_o[k*XLEN +: XLEN];
  end
  assign pd_b = bus_b.read_pending_o;
  assign pd_n = bus_n.read_pending_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs/outputs settle away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    raddr = {a2, a1, a0};
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      edges++;
      if (bus_n.ready_o === 1'b1) break;
    end
  endtask

  int edges;

  initial begin
    // Reset and reset-state values
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready_b", {31'd0, bus_b.ready_o}, 32'd0);
    check("rst_ready_n", {31'd0, bus_n.ready_o}, 32'd0);
    check("rst_state", {31'd0, st_n}, {31'd0, CLEAR});
    rst = 1'b0;

    // Clear timing with a write to x5 held every cycle
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    set_rd(5'd5, 5'd5, 5'd5);
    #1;
    check("clear_rd_b", rd_b[0], 32'd0);
    check("clear_pend_b", {29'd0, pd_b}, 32'd0);
    wait_ready(edges);
    check("clear_edges", edges, 32'd31);
    check("clear_ready_b", {31'd0, bus_b.ready_o}, 32'd1);
    we = 1'b0;
    #1;
    check("drop_x5_n", rd_n[0], 32'd0);
    check("drop_x5_b", rd_b[0], 32'd0);
    we = 1'b1;
    #1;
    check("first_wr_byp", rd_b[0], 32'hDEADBEEF);
    check("first_wr_nobyp", rd_n[0], 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("first_wr_n", rd_n[0], 32'hDEADBEEF);

    // Basic three-port read
    we = 1'b1; wa = 5'd1; wd = 32'hAAAAAAAA; tick();
    wa = 5'd2; wd = 32'h55555555; tick();
    we = 1'b0;
    set_rd(5'd1, 5'd2, 5'd0);
    #1;
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'h55555555);
    exp_q.push_back(32'h0);
    for (int k = 0; k < NRD; k++) begin
      logic [XLEN-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("basic_n_p%0d", k), rd_n[k], e);
      check($sformatf("basic_b_p%0d", k), rd_b[k], e);
    end

    // Zero register: write and pend_set x0
    set_rd(5'd0, 5'd0, 5'd0);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    #1;
    check("x0_wr_byp", rd_b[0], 32'd0);
    tick();
    we = 1'b0; ps = 1'b1; pa = 5'd0; tick();
    ps = 1'b0;
    #1;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("x0_data_p%0d", k), rd_n[k], 32'd0);
    end
    check("x0_pend_n", {29'd0, pd_n}, 32'd0);
    check("x0_pend_b", {29'd0, pd_b}, 32'd0);

    // Bypass
    we = 1'b1; wa = 5'd3; wd = 32'h11; tick();
    set_rd(5'd0, 5'd3, 5'd0);
    wd = 32'h22;
    #1;
    check("byp_on", rd_b[1], 32'h22);
    check("byp_off", rd_n[1], 32'h11);
    tick();
    we = 1'b0;
    #1;
    check("byp_off_after", rd_n[1], 32'h22);

    // Scoreboard set, clear by write, and same-cycle set+write
    set_rd(5'd0, 5'd0, 5'd7);
    ps = 1'b1; pa = 5'd7;
    #1;
    check("sb_before", {31'd0, pd_n[2]}, 32'd0);
    tick();
    ps = 1'b0;
    #1;
    check("sb_set_n", {31'd0, pd_n[2]}, 32'd1);
    check("sb_set_b", {31'd0, pd_b[2]}, 32'd1);
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    #1;
    check("sb_wr_byp_pend", {31'd0, pd_b[2]}, 32'd0);
    check("sb_wr_nobyp_pend", {31'd0, pd_n[2]}, 32'd1);
    tick();
    we = 1'b0;
    #1;
    check("sb_clr_n", {31'd0, pd_n[2]}, 32'd0);
    check("sb_clr_data", rd_n[2], 32'h77);
    we = 1'b1; wa = 5'd7; wd = 32'h99; ps = 1'b1; pa = 5'd7;
    #1;
    check("sb_both_byp_data", rd_b[2], 32'h99);
    check("sb_both_byp_pend", {31'd0, pd_b[2]}, 32'd1);
    tick();
    we = 1'b0; ps = 1'b0;
    set_rd(5'd7, 5'd7, 5'd7);
    #1;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("sb_both_data_p%0d", k), rd_n[k], 32'h99);
    end
    check("sb_both_pend_n", {29'd0, pd_n}, 32'd7);

    // Reset mid-clear at index 10
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_ready", {31'd0, bus_n.ready_o}, 32'd0);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("mid_ready_rst", {31'd0, bus_b.ready_o}, 32'd0);
    wait_ready(edges);
    check("mid_edges", edges, 32'd31);
    check("mid_x7_data", rd_n[0], 32'd0);
    check("mid_x7_pend", {29'd0, pd_n}, 32'd0);
    check("mid_state", {31'd0, st_b}, {31'd0, READY});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
